exe_stage_unit: RTL and testbench

- Execute stage of the 5-stage ARM pipeline; consumes the ID/EXE register outputs and the second-operand value from the second-operand generator.
- Contains the ALU, the NZCV status register and the branch-target adder, and drives the EXE/MEM pipeline register.
- Status flags feed back to the ID-stage condition check. The branch target and taken signal feed back to IF.

---
 rtl/arm_exe_pkg.sv | 25 ++
 rtl/arm_alu.sv | 47 ++++
 rtl/exe_stage_unit.sv | 98 +++++++++
 tb/tb_exe_stage_unit.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/arm_exe_pkg.sv
// arm_exe_pkg: ALU command codes, status bit positions and forward-select codes for the EXE stage.
package arm_exe_pkg;
  localparam logic [3:0] EXE_MOV = 4'b0001;
  localparam logic [3:0] EXE_MVN = 4'b1001;
  localparam logic [3:0] EXE_ADD = 4'b0010;
  localparam logic [3:0] EXE_ADC = 4'b0011;
  localparam logic [3:0] EXE_SUB = 4'b0100;
  localparam logic [3:0] EXE_SBC = 4'b0101;
  localparam logic [3:0] EXE_AND = 4'b0110;
  localparam logic [3:0] EXE_ORR = 4'b0111;
  localparam logic [3:0] EXE_EOR = 4'b1000;
  localparam int ST_N = 3;
  localparam int ST_Z = 2;
  localparam int ST_C = 1;
  localparam int ST_V = 0;
  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;
  function automatic logic cmd_valid(input logic [3:0] cmd);
    return cmd inside {EXE_MOV, EXE_MVN, EXE_ADD, EXE_ADC, EXE_SUB, EXE_SBC, EXE_AND, EXE_ORR, EXE_EOR};
  endfunction
  function automatic logic cmd_arith(input logic [3:0] cmd);
    return cmd inside {EXE_ADD, EXE_ADC, EXE_SUB, EXE_SBC};
  endfunction
endpackage

// File: rtl/arm_alu.sv
// arm_alu: combinational ALU computing at DATA_W+1 bits; c is NOT borrow for subtracts.
module arm_alu
  import arm_exe_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              cin,
  input  logic [3:0]        cmd,
  output logic [DATA_W-1:0] res,
  output logic              n,
  output logic              z,
  output logic              c,
  output logic              v
);
  logic [DATA_W:0] sum;
  logic            sub;
  always_comb begin
    sum = '0;
    sub = 1'b0;
    case (cmd)
      EXE_MOV: sum = {1'b0, b};
      EXE_MVN: sum = {1'b0, ~b};
      EXE_ADD: sum = {1'b0, a} + {1'b0, b};
      EXE_ADC: sum = {1'b0, a} + {1'b0, b} + {{DATA_W{1'b0}}, cin};
      EXE_SUB: begin
        sum = {1'b0, a} - {1'b0, b};
        sub = 1'b1;
      end
      EXE_SBC: begin
        sum = {1'b0, a} - {1'b0, b} - {{DATA_W{1'b0}}, ~cin};
        sub = 1'b1;
      end
      EXE_AND: sum = {1'b0, a & b};
      EXE_ORR: sum = {1'b0, a | b};
      EXE_EOR: sum = {1'b0, a ^ b};
      default: sum = '0;
    endcase
  end
  assign res = sum[DATA_W-1:0];
  assign n   = res[DATA_W-1];
  assign z   = res == '0;
  assign c   = sub ? ~sum[DATA_W] : sum[DATA_W];
  // Overflow when effective operand signs agree but the result sign differs.
  assign v   = (sub ? (a[DATA_W-1] != b[DATA_W-1]) : (a[DATA_W-1] == b[DATA_W-1])) && (res[DATA_W-1] != a[DATA_W-1]);
endmodule

// File: rtl/exe_stage_unit.sv
// exe_stage_unit: ARM execute stage with ALU, NZCV register, branch adder and EXE/MEM register.
// Define FORWARDING_EN to add operand forwarding ports for the first operand and store data.
module exe_stage_unit
  import arm_exe_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  freeze,
  input  logic [3:0]            exe_cmd,
  input  logic                  s_in,
  input  logic                  b_in,
  input  logic                  mem_r_en_in,
  input  logic                  mem_w_en_in,
  input  logic                  wb_en_in,
  input  logic [DATA_W-1:0]     pc_in,
  input  logic [DATA_W-1:0]     val_rn,
  input  logic [DATA_W-1:0]     val2,
  input  logic [DATA_W-1:0]     val_rm,
  input  logic [23:0]           imm24,
  input  logic [REG_ADDR_W-1:0] dest_in,
  output logic [3:0]            status,
  output logic                  branch_taken,
  output logic [DATA_W-1:0]     branch_addr,
  output logic [DATA_W-1:0]     alu_res,
  output logic [DATA_W-1:0]     st_val,
  output logic [REG_ADDR_W-1:0] dest,
  output logic                  mem_r_en,
  output logic                  mem_w_en,
  output logic                  wb_en
`ifdef FORWARDING_EN
  ,
  input  logic [1:0]            sel_src1,
  input  logic [1:0]            sel_src2,
  input  logic [DATA_W-1:0]     mem_fwd_val,
  input  logic [DATA_W-1:0]     wb_fwd_val
`endif
);
  logic [DATA_W-1:0]     op_a, st_d, alu_d;
  logic [DATA_W-1:0]     alu_res_q, st_val_q;
  logic [REG_ADDR_W-1:0] dest_q;
  logic [3:0]            status_q, status_d;
  logic                  mem_r_en_q, mem_w_en_q, wb_en_q;
  logic                  n, z, c, v, arith;
`ifdef FORWARDING_EN
  assign op_a = sel_src1 == FWD_MEM ? mem_fwd_val : sel_src1 == FWD_WB ? wb_fwd_val : val_rn;
  assign st_d = sel_src2 == FWD_MEM ? mem_fwd_val : sel_src2 == FWD_WB ? wb_fwd_val : val_rm;
`else
  assign op_a = val_rn;
  assign st_d = val_rm;
`endif
  arm_alu #(.DATA_W(DATA_W)) u_alu (
    .a  (op_a),
    .b  (val2),
    .cin(status_q[ST_C]),
    .cmd(exe_cmd),
    .res(alu_d),
    .n  (n),
    .z  (z),
    .c  (c),
    .v  (v)
  );
  // Logical ops and moves leave C and V alone; unknown codes leave every flag alone.
  assign arith    = cmd_arith(exe_cmd);
  assign status_d = (s_in && cmd_valid(exe_cmd))
                  ? {n, z, arith ? c : status_q[ST_C], arith ? v : status_q[ST_V]}
                  : status_q;
  always_ff @(posedge clk) begin
    if (!rst) begin
      status_q   <= '0;
      alu_res_q  <= '0;
      st_val_q   <= '0;
      dest_q     <= '0;
      mem_r_en_q <= 1'b0;
      mem_w_en_q <= 1'b0;
      wb_en_q    <= 1'b0;
    end else if (!freeze) begin
      status_q   <= status_d;
      alu_res_q  <= alu_d;
      st_val_q   <= st_d;
      dest_q     <= dest_in;
      mem_r_en_q <= mem_r_en_in;
      mem_w_en_q <= mem_w_en_in;
      wb_en_q    <= wb_en_in;
    end
  end
  assign branch_taken = b_in;
  assign branch_addr  = pc_in + {{(DATA_W-26){imm24[23]}}, imm24, 2'b00};
  assign status       = status_q;
  assign alu_res      = alu_res_q;
  assign st_val       = st_val_q;
  assign dest         = dest_q;
  assign mem_r_en     = mem_r_en_q;
  assign mem_w_en     = mem_w_en_q;
  assign wb_en        = wb_en_q;
endmodule

// File: tb/tb_exe_stage_unit.sv
// tb_exe_stage_unit: directed and randomized checks of exe_stage_unit against an arithmetic reference model.
module tb_exe_stage_unit;
  logic        clk = 1'b0;
  logic        rst, freeze, s_in, b_in, mem_r_en_in, mem_w_en_in, wb_en_in;
  logic [3:0]  exe_cmd, dest_in;
  logic [31:0] pc_in, val_rn, val2, val_rm;
  logic [23:0] imm24;
  logic [3:0]  status, dest;
  logic        branch_taken, mem_r_en, mem_w_en, wb_en;
  logic [31:0] branch_addr, alu_res, st_val;
  logic [1:0]  sel_src1, sel_src2;
  logic [31:0] mem_fwd_val, wb_fwd_val;
  logic [3:0]  m_status, m_dest;
  logic [31:0] m_alu, m_st;
  logic [2:0]  m_ctl;
  int n_tests = 0;
  int n_fail  = 0;
  always #5 clk = ~clk;
  exe_stage_unit dut (
    .clk(clk), .rst(rst), .freeze(freeze), .exe_cmd(exe_cmd), .s_in(s_in), .b_in(b_in),
    .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in), .wb_en_in(wb_en_in),
    .pc_in(pc_in), .val_rn(val_rn), .val2(val2), .val_rm(val_rm), .imm24(imm24), .dest_in(dest_in),
    .status(status), .branch_taken(branch_taken), .branch_addr(branch_addr), .alu_res(alu_res),
    .st_val(st_val), .dest(dest), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .wb_en(wb_en)
`ifdef FORWARDING_EN
    , .sel_src1(sel_src1), .sel_src2(sel_src2), .mem_fwd_val(mem_fwd_val), .wb_fwd_val(wb_fwd_val)
`endif
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic model_step;
    longint ua, ub, sa, sb, r, sr, ci;
    logic [31:0] a, st, res;
    logic valid, arith, is_sub, cn, cv;
    a = val_rn;
    st = val_rm;
`ifdef FORWARDING_EN
    if (sel_src1 == 2'b01) a = mem_fwd_val; else if (sel_src1 == 2'b10) a = wb_fwd_val;
    if (sel_src2 == 2'b01) st = mem_fwd_val; else if (sel_src2 == 2'b10) st = wb_fwd_val;
`endif
    ua = longint'(a);
    ub = longint'(val2);
    sa = longint'($signed(a));
    sb = longint'($signed(val2));
    ci = m_status[1] ? 64'sd1 : 64'sd0;
    valid = 1'b1; arith = 1'b1; is_sub = 1'b0;
    r = 0; sr = 0; res = '0;
    case (exe_cmd)
      4'd1: begin res = val2;       arith = 1'b0; end
      4'd9: begin res = ~val2;      arith = 1'b0; end
      4'd6: begin res = a & val2;   arith = 1'b0; end
      4'd7: begin res = a | val2;   arith = 1'b0; end
      4'd8: begin res = a ^ val2;   arith = 1'b0; end
      4'd2: begin r = ua + ub;      sr = sa + sb; end
      4'd3: begin r = ua + ub + ci; sr = sa + sb + ci; end
      4'd4: begin r = ua - ub;      sr = sa - sb; is_sub = 1'b1; end
      4'd5: begin r = ua - ub - (1 - ci); sr = sa - sb - (1 - ci); is_sub = 1'b1; end
      default: begin valid = 1'b0; arith = 1'b0; end
    endcase
    if (arith) res = r[31:0];
    cn = arith ? (is_sub ? (r >= 0) : (r >= 64'sd4294967296)) : m_status[1];
    cv = arith ? (sr > 64'sd2147483647 || sr < -64'sd2147483648) : m_status[0];
    if (!rst) begin
      m_status = '0; m_alu = '0; m_st = '0; m_dest = '0; m_ctl = '0;
    end else if (!freeze) begin
      if (s_in && valid) m_status = {res[31], res == 32'd0, cn, cv};
      m_alu = res;
      m_st = st;
      m_dest = dest_in;
      m_ctl = {mem_r_en_in, mem_w_en_in, wb_en_in};
    end
  endtask
  task automatic cycle;
    @(negedge clk);
    check("br_taken", {31'b0, branch_taken}, {31'b0, b_in});
    check("br_addr", branch_addr, pc_in + 32'(int'($signed(imm24)) * 4));
    model_step;
    @(posedge clk);
    #1;
    check("alu_res", alu_res, m_alu);
    check("st_val", st_val, m_st);
    check("dest", {28'b0, dest}, {28'b0, m_dest});
    check("ctl", {29'b0, mem_r_en, mem_w_en, wb_en}, {29'b0, m_ctl});
    check("status", {28'b0, status}, {28'b0, m_status});
  endtask
  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction
  task automatic rand_inputs;
    exe_cmd = 4'($urandom_range(0, 15));
    s_in = 1'($urandom); b_in = 1'($urandom);
    mem_r_en_in = 1'($urandom); mem_w_en_in = 1'($urandom); wb_en_in = 1'($urandom);
    pc_in = $urandom; val_rn = pick_val(); val2 = pick_val(); val_rm = $urandom;
    imm24 = 24'($urandom); dest_in = 4'($urandom);
    sel_src1 = 2'($urandom); sel_src2 = 2'($urandom);
    mem_fwd_val = pick_val(); wb_fwd_val = $urandom;
  endtask
  task automatic op(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b);
    exe_cmd = cmd; val_rn = a; val2 = b; s_in = 1'b1; freeze = 1'b0; b_in = 1'b0;
    sel_src1 = 2'b00; sel_src2 = 2'b00;
    cycle;
  endtask
  initial begin
    m_status = '0; m_alu = '0; m_st = '0; m_dest = '0; m_ctl = '0;
    rand_inputs;
    rst = 1'b0; freeze = 1'($urandom);
    @(posedge clk);
    #1;
    repeat (2) begin rand_inputs; cycle; end
    check("rst_status", {28'b0, status}, 32'h0);
    check("rst_alu", alu_res, 32'h0);
    rst = 1'b1;
    op(4'b0010, 32'hFFFF_FFFF, 32'h1);
    check("add_wrap", alu_res, 32'h0);
    check("add_flags", {28'b0, status}, 32'h6);
    op(4'b0011, 32'd5, 32'd3);
    check("adc_cin", alu_res, 32'd9);
    op(4'b0100, 32'h8000_0000, 32'h1);
    check("sub_wrap", alu_res, 32'h7FFF_FFFF);
    check("sub_flags", {28'b0, status}, 32'h3);
    op(4'b0110, 32'hF0, 32'h0F);
    check("and_res", alu_res, 32'h0);
    check("and_flags", {28'b0, status}, 32'h7);
    freeze = 1'b1; exe_cmd = 4'b0001; val2 = 32'h1234; s_in = 1'b1;
    repeat (3) cycle;
    check("frz_alu", alu_res, 32'h0);
    check("frz_status", {28'b0, status}, 32'h7);
    freeze = 1'b0;
    cycle;
    check("unfrz_alu", alu_res, 32'h1234);
    check("mov_flags", {28'b0, status}, 32'h3);
    b_in = 1'b1; pc_in = 32'h100; imm24 = 24'hFFFFFE;
    #1;
    check("br_back", branch_addr, 32'hF8);
    check("br_tk", {31'b0, branch_taken}, 32'h1);
    imm24 = 24'h000004;
    #1;
    check("br_fwd", branch_addr, 32'h110);
`ifdef FORWARDING_EN
    exe_cmd = 4'b0010; sel_src1 = 2'b01; mem_fwd_val = 32'd7; val2 = 32'd3; val_rn = 32'd100;
    sel_src2 = 2'b10; wb_fwd_val = 32'hAA; val_rm = 32'h55;
    cycle;
    check("fwd_a", alu_res, 32'd10);
    check("fwd_st", st_val, 32'hAA);
`endif
    repeat (400) begin
      rand_inputs;
      rst = $urandom_range(0, 19) != 0;
      freeze = $urandom_range(0, 4) == 0;
      cycle;
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
